// File: rtl/hd_bitscan_pkg.sv
// Shared types for the multi-cycle bit-scan unit: operand modes, FSM states,
// and the result-width helper.
package hd_bitscan_pkg;

  typedef enum logic [1:0] {
    MODE_CLZ    = 2'd0,
    MODE_CTZ    = 2'd1,
    MODE_POPCNT = 2'd2,
    MODE_PARITY = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold any count 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hd_chunk_scan.sv
// Combinational scan of one CHUNK-bit slice: leading/trailing zero counts,
// popcount, parity and a nonzero flag.
module hd_chunk_scan
  import hd_bitscan_pkg::*;
#(
  parameter  int CHUNK = 8,
  localparam int SW    = cnt_w(CHUNK)
) (
  input  logic [CHUNK-1:0] i_slice,
  output logic [SW-1:0]    o_lzc,
  output logic [SW-1:0]    o_tzc,
  output logic [SW-1:0]    o_pop,
  output logic             o_par,
  output logic             o_nz
);

  // An all-zero slice reports CHUNK for both zero counts, so the caller can
  // add the count unconditionally.
  always_comb begin
    o_lzc = SW'(CHUNK);
    o_tzc = SW'(CHUNK);
    o_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i_slice[i]) o_lzc = SW'(CHUNK - 1 - i);
      o_pop = o_pop + SW'(i_slice[i]);
    end
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (i_slice[i]) o_tzc = SW'(i);
    end
  end

  assign o_par = ^i_slice;
  assign o_nz  = |i_slice;

endmodule

// File: rtl/hd_bitscan_seq.sv
// Sequential CLZ/CTZ/POPCNT/PARITY engine consuming CHUNK bits per cycle,
// with valid/ready on both sides and early exit for the zero counts.
module hd_bitscan_seq
  import hd_bitscan_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [1:0]       i_in_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_out_count,
  output logic             o_out_zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = cnt_w(CHUNK);

  state_t           r_state, w_next;
  mode_t            r_mode;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic             r_nz;

  logic [CHUNK-1:0] w_slice;
  logic [SW-1:0]    w_lzc, w_tzc, w_pop;
  logic             w_par, w_nz, w_clx, w_last, w_stop, w_accept;

  // CLZ walks from the MSB end; every other mode walks from the LSB end.
  assign w_slice  = (r_mode == MODE_CLZ) ? r_sh[WIDTH-1 -: CHUNK] : r_sh[CHUNK-1:0];
  assign w_clx    = (r_mode == MODE_CLZ) || (r_mode == MODE_CTZ);
  assign w_last   = (r_idx == IW'(NCH - 1));
  assign w_stop   = w_clx & w_nz;
  assign w_accept = i_in_valid & (r_state == ST_IDLE);

  hd_chunk_scan #(.CHUNK(CHUNK)) u_scan (
    .i_slice (w_slice),
    .o_lzc   (w_lzc),
    .o_tzc   (w_tzc),
    .o_pop   (w_pop),
    .o_par   (w_par),
    .o_nz    (w_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_count = '0;
    o_out_zero  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last || w_stop) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        o_out_count = r_acc;
        o_out_zero  = ~r_nz;
        if (i_out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_mode <= MODE_CLZ;
      r_acc  <= '0;
      r_idx  <= '0;
      r_nz   <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= i_in_data;
      r_mode <= mode_t'(i_in_mode);
      r_acc  <= '0;
      r_idx  <= '0;
      r_nz   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_sh  <= (r_mode == MODE_CLZ) ? (r_sh << CHUNK) : (r_sh >> CHUNK);
      r_idx <= r_idx + IW'(1);
      if (w_nz) r_nz <= 1'b1;
      case (r_mode)
        MODE_CLZ:    r_acc    <= r_acc + CNT_W'(w_lzc);
        MODE_CTZ:    r_acc    <= r_acc + CNT_W'(w_tzc);
        MODE_POPCNT: r_acc    <= r_acc + CNT_W'(w_pop);
        default:     r_acc[0] <= r_acc[0] ^ w_par;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_bitscan_seq.sv
// Bench for hd_bitscan_seq: directed cases on a 32/8 instance, reset mid-run,
// and random operands on 32/8, 16/4 and 64/16 instances against a bit-level model.
module tb_hd_bitscan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [3];
  logic        ordy[3];
  logic [63:0] din [3];
  logic [1:0]  md  [3];
  logic        rdy [3];
  logic        ov  [3];
  logic        zr  [3];
  logic [5:0]  cnt0;
  logic [4:0]  cnt1;
  logic [6:0]  cnt2;
  logic [63:0] cnt [3];

  int errors = 0;
  int checks = 0;
  int W[3] = '{32, 16, 64};
  int C[3] = '{8, 4, 16};

  always #5 clk = ~clk;

  assign cnt[0] = 64'(cnt0);
  assign cnt[1] = 64'(cnt1);
  assign cnt[2] = 64'(cnt2);

  hd_bitscan_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(vld[0]), .o_in_ready(rdy[0]),
    .i_in_data(din[0][31:0]), .i_in_mode(md[0]), .o_out_valid(ov[0]),
    .i_out_ready(ordy[0]), .o_out_count(cnt0), .o_out_zero(zr[0]));

  hd_bitscan_seq #(.WIDTH(16), .CHUNK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(vld[1]), .o_in_ready(rdy[1]),
    .i_in_data(din[1][15:0]), .i_in_mode(md[1]), .o_out_valid(ov[1]),
    .i_out_ready(ordy[1]), .o_out_count(cnt1), .o_out_zero(zr[1]));

  hd_bitscan_seq #(.WIDTH(64), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(vld[2]), .o_in_ready(rdy[2]),
    .i_in_data(din[2]), .i_in_mode(md[2]), .o_out_valid(ov[2]),
    .i_out_ready(ordy[2]), .o_out_count(cnt2), .o_out_zero(zr[2]));

  task automatic chk(input string tag, input int u, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  // Bit-level reference: scan the operand as a whole, then derive the RUN
  // length from where the first 1 sits relative to chunk boundaries.
  function automatic void model(input logic [63:0] d, input int w, input int c, input int m,
                                output int res, output bit zero, output int k);
    int lz, tz, pop;
    bit seen;
    lz = w; tz = w; pop = 0; seen = 0;
    for (int i = w - 1; i >= 0; i--) if (d[i] && !seen) begin lz = w - 1 - i; seen = 1; end
    seen = 0;
    for (int i = 0; i < w; i++) begin
      if (d[i]) pop++;
      if (d[i] && !seen) begin tz = i; seen = 1; end
    end
    zero = (pop == 0);
    case (m)
      0:       res = lz;
      1:       res = tz;
      2:       res = pop;
      default: res = pop % 2;
    endcase
    if (m < 2 && !zero) k = res / c + 1;
    else                k = w / c;
  endfunction

  task automatic run_op(input int u, input logic [63:0] data, input int m, input int hold);
    int ec, k, cyc;
    bit ez;
    model(data, W[u], C[u], m, ec, ez, k);
    @(negedge clk);
    cyc = 0;
    while (!rdy[u] && cyc < 100) begin @(negedge clk); cyc++; end
    chk("in_ready_idle", u, 64'(rdy[u]), 64'd1);
    vld[u] = 1'b1; din[u] = data; md[u] = 2'(m);
    @(posedge clk);
    @(negedge clk);
    vld[u] = 1'b0; din[u] = {$urandom, $urandom}; md[u] = 2'($urandom);
    cyc = 1;
    while (!ov[u] && cyc < 300) begin @(negedge clk); cyc++; end
    chk("latency", u, 64'(cyc), 64'(k + 1));
    chk("count", u, cnt[u], 64'(ec));
    chk("zero", u, 64'(zr[u]), 64'(ez));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_count", u, cnt[u], 64'(ec));
      chk("hold_valid", u, 64'(ov[u]), 64'd1);
      chk("hold_in_ready", u, 64'(rdy[u]), 64'd0);
    end
    ordy[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[u] = 1'b0;
    chk("in_ready_after", u, 64'(rdy[u]), 64'd1);
    chk("valid_after", u, 64'(ov[u]), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; ordy[i] = 1'b0; din[i] = '0; md[i] = '0;
    end
    #12;
    chk("rst_in_ready", 0, 64'(rdy[0]), 64'd1);
    chk("rst_out_valid", 0, 64'(ov[0]), 64'd0);
    chk("rst_count", 0, cnt[0], 64'd0);
    chk("rst_zero", 0, 64'(zr[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 64'h0000_0001, 0, 0);
    run_op(0, 64'h8000_0000, 0, 0);
    run_op(0, 64'h8000_0000, 1, 0);
    run_op(0, 64'h0000_0000, 0, 0);
    run_op(0, 64'h0000_0000, 1, 0);
    run_op(0, 64'hFFFF_FFFF, 2, 0);
    run_op(0, 64'h0000_0007, 3, 0);
    run_op(0, 64'h0001_0000, 1, 10);

    // Abort a POPCNT in its second RUN cycle.
    @(negedge clk);
    vld[0] = 1'b1; din[0] = 64'hFFFF_FFFF; md[0] = 2'd2;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_in_ready", 0, 64'(rdy[0]), 64'd1);
    chk("midrun_out_valid", 0, 64'(ov[0]), 64'd0);
    chk("midrun_count", 0, cnt[0], 64'd0);
    chk("midrun_zero", 0, 64'(zr[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 64'h0F0F_0F0F, 2, 0);

    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 14; n++) begin
        logic [63:0] d;
        d = {$urandom, $urandom} >> $urandom_range(0, 64);
        if (W[u] < 64) d = d & ((64'd1 << W[u]) - 64'd1);
        run_op(u, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
